// File: rtl/am_pkg.sv
// Shared constants and helpers for the AM transmitter datapath.
// Latency: n/a (package only).
// Backpressure: n/a.
// Holds NCO/sample widths, sigma-delta scaling and the dither LFSR
// definition (used only when AM_TX_DITHER_EN is defined).
package am_pkg;

  localparam int PHASE_W  = 26;
  localparam int SAMPLE_W = 8;
  localparam int SD_FS    = 32768;
  localparam int SD_ACC_W = 18;

  localparam logic [15:0] LFSR_SEED = 16'hACE1;
  // Taps for x^16 + x^14 + x^13 + x^11 + 1 (register bits 15, 13, 12, 10).
  localparam logic [15:0] LFSR_TAPS = 16'hB400;

  // Signed triangle from the top 9 phase bits: bit 8 selects polarity,
  // bit 7 selects the falling half of each quarter pair.
  function automatic logic signed [7:0] tri_wave(input logic [8:0] top);
    logic [6:0] mag;
    mag      = top[7] ? ~top[6:0] : top[6:0];
    tri_wave = top[8] ? -$signed({1'b0, mag}) : $signed({1'b0, mag});
  endfunction

endpackage

// File: rtl/am_tx_lite_if.sv
// Control/data bundle between an audio source and the AM transmitter.
// Latency: n/a (wires only).
// Backpressure: none; audio_tick is a one-cycle strobe, no ready return.
// Signals: tx_en, phase_inc, audio_in, audio_tick, mod_shift (to DUT),
//          RF_out (from DUT). master = source side, slave = transmitter.
interface am_tx_lite_if #(
  parameter int PHASE_W  = am_pkg::PHASE_W,
  parameter int SAMPLE_W = am_pkg::SAMPLE_W
);
  logic                tx_en;
  logic [PHASE_W-1:0]  phase_inc;
  logic [SAMPLE_W-1:0] audio_in;
  logic                audio_tick;
  logic [1:0]          mod_shift;
  logic                RF_out;

  modport master (
    output tx_en, phase_inc, audio_in, audio_tick, mod_shift,
    input  RF_out
  );

  modport slave (
    input  tx_en, phase_inc, audio_in, audio_tick, mod_shift,
    output RF_out
  );
endinterface

// File: rtl/nco_tri.sv
// Carrier NCO: free-running phase accumulator plus signed triangle shaper.
// Latency: phase register -> tri_out 1 clock.
// Backpressure: none; runs every clock regardless of transmit enable.
// Ports: CLK, RSTb (async active-low), phase_inc (per-clock step),
//        tri_out (signed -127..+127 carrier).
module nco_tri #(
  parameter int PHASE_W = am_pkg::PHASE_W
) (
  input  logic                CLK,
  input  logic                RSTb,
  input  logic [PHASE_W-1:0]  phase_inc,
  output logic signed [7:0]   tri_out
);
  import am_pkg::*;

  logic [PHASE_W-1:0] phase_q, phase_d;
  logic signed [7:0]  tri_q, tri_d;

  always_comb begin
    phase_d = phase_q + phase_inc;  // wraps modulo 2^PHASE_W
    tri_d   = tri_wave(phase_q[PHASE_W-1 -: 9]);
  end

  always_ff @(posedge CLK or negedge RSTb) begin
    if (!RSTb) begin
      phase_q <= '0;
      tri_q   <= '0;
    end else begin
      phase_q <= phase_d;
      tri_q   <= tri_d;
    end
  end

  assign tri_out = tri_q;

endmodule

// File: rtl/am_tx_lite.sv
// 1-bit sigma-delta AM transmitter: envelope x triangle carrier -> RF_out.
// Latency: phase/audio register -> RF_out 3 clocks (S0 -> S3).
// Backpressure: none; audio accepted on any audio_tick, every cycle legal.
// Ports: CLK, RSTb (async active-low), bus (am_tx_lite_if.slave).
// Option: define AM_TX_DITHER_EN to add -8..+7 LFSR dither to the modulator.
module am_tx_lite #(
  parameter int PHASE_W  = am_pkg::PHASE_W,
  parameter int SAMPLE_W = am_pkg::SAMPLE_W  // only 8 is supported
) (
  input  logic         CLK,
  input  logic         RSTb,
  am_tx_lite_if.slave  bus
);
  import am_pkg::*;

  localparam logic signed [SD_ACC_W-1:0] FS_POS = SD_ACC_W'(SD_FS);
  localparam logic signed [SD_ACC_W-1:0] FS_NEG = -FS_POS;

  logic signed [7:0]          tri_w;
  logic signed [SAMPLE_W-1:0] audio_hold_q, audio_hold_d;
  logic signed [SAMPLE_W-1:0] aud_shift;
  logic [7:0]                 env_q, env_d;
  logic signed [15:0]         env_ext, tri_ext;
  logic signed [15:0]         prod_q, prod_d;
  logic signed [SD_ACC_W-1:0] x, fb, acc_sum;
  logic signed [SD_ACC_W-1:0] acc_q, acc_d;
  logic                       rf_q, rf_d;
`ifdef AM_TX_DITHER_EN
  localparam logic signed [SD_ACC_W-1:0] DITH_OFS = SD_ACC_W'(8);
  logic [15:0]                lfsr_q, lfsr_d;
  logic signed [SD_ACC_W-1:0] dith;
`endif

  nco_tri #(.PHASE_W(PHASE_W)) u_nco (
    .CLK       (CLK),
    .RSTb      (RSTb),
    .phase_inc (bus.phase_inc),
    .tri_out   (tri_w)
  );

  always_comb begin
    // S0: audio holding register
    audio_hold_d = audio_hold_q;
    if (bus.audio_tick) audio_hold_d = bus.audio_in;

    // S1: offset-binary envelope; +128 on a signed byte never leaves 0..255
    aud_shift = audio_hold_q >>> bus.mod_shift;
    env_d     = unsigned'(aud_shift) + 8'd128;

    // S2: envelope (unsigned) times carrier (signed), both sign-correct at 16b
    env_ext = {8'd0, env_q};
    tri_ext = {{8{tri_w[7]}}, tri_w};
    prod_d  = env_ext * tri_ext;

    // S3: first-order sigma-delta; |x| < SD_FS keeps acc within +/-2*SD_FS
    x = {{(SD_ACC_W-16){prod_q[15]}}, prod_q};
`ifdef AM_TX_DITHER_EN
    dith   = $signed({{(SD_ACC_W-4){1'b0}}, lfsr_q[3:0]}) - DITH_OFS;
    x      = x + dith;
    lfsr_d = lfsr_q;
    if (bus.tx_en) lfsr_d = {lfsr_q[14:0], ^(lfsr_q & LFSR_TAPS)};
`endif
    fb      = rf_q ? FS_POS : FS_NEG;
    acc_sum = acc_q + x - fb;

    // Muted: modulator parked at zero so it restarts cleanly on enable
    acc_d = '0;
    rf_d  = 1'b0;
    if (bus.tx_en) begin
      acc_d = acc_sum;
      rf_d  = ~acc_sum[SD_ACC_W-1];
    end
  end

  always_ff @(posedge CLK or negedge RSTb) begin
    if (!RSTb) begin
      audio_hold_q <= '0;
      env_q        <= '0;
      prod_q       <= '0;
      acc_q        <= '0;
      rf_q         <= 1'b0;
`ifdef AM_TX_DITHER_EN
      lfsr_q       <= LFSR_SEED;
`endif
    end else begin
      audio_hold_q <= audio_hold_d;
      env_q        <= env_d;
      prod_q       <= prod_d;
      acc_q        <= acc_d;
      rf_q         <= rf_d;
`ifdef AM_TX_DITHER_EN
      lfsr_q       <= lfsr_d;
`endif
    end
  end

  assign bus.RF_out = rf_q;

endmodule

// File: tb/tb_am_tx_lite.sv
// Self-checking bench for am_tx_lite: cycle model feeds a scoreboard of
// expected RF_out bits, plus targeted checks on reset, mute, envelope.
module tb_am_tx_lite;

  logic CLK = 1'b0;
  logic RSTb;
  always #5 CLK = ~CLK;

  am_tx_lite_if #(.PHASE_W(26), .SAMPLE_W(8)) bus ();

  am_tx_lite dut (
    .CLK  (CLK),
    .RSTb (RSTb),
    .bus  (bus)
  );

  int checks = 0;
  int errors = 0;
  int ones   = 0;
  bit exp_q[$];

  // Reference model state
  int m_phase, m_hold, m_env, m_tri, m_prod, m_acc, m_rf, m_lfsr;

  function automatic int tri_of(int p);
    int v, mag;
    v   = (p >> 17) & 127;
    mag = ((p >> 24) & 1) ? (127 - v) : v;
    return ((p >> 25) & 1) ? -mag : mag;
  endfunction

  task automatic model_reset();
    m_phase = 0; m_hold = 0; m_env = 0; m_tri = 0;
    m_prod = 0; m_acc = 0; m_rf = 0; m_lfsr = 'hACE1;
  endtask

  task automatic model_step();
    int x, n_acc;
    if (RSTb !== 1'b1) begin
      model_reset();
      return;
    end
    x = m_prod;
`ifdef AM_TX_DITHER_EN
    x = x + (m_lfsr & 15) - 8;
`endif
    if (bus.tx_en === 1'b1) begin
      n_acc = m_acc + x - (m_rf != 0 ? 32768 : -32768);
      m_acc = n_acc;
      m_rf  = (n_acc >= 0) ? 1 : 0;
`ifdef AM_TX_DITHER_EN
      m_lfsr = ((m_lfsr << 1) & 'hFFFF) |
               (((m_lfsr >> 15) ^ (m_lfsr >> 13) ^ (m_lfsr >> 12) ^ (m_lfsr >> 10)) & 1);
`endif
    end else begin
      m_acc = 0;
      m_rf  = 0;
    end
    m_prod = m_env * m_tri;
    m_env  = 128 + (m_hold >>> bus.mod_shift);
    m_tri  = tri_of(m_phase);
    if (bus.audio_tick === 1'b1) m_hold = int'($signed(bus.audio_in));
    m_phase = (m_phase + int'(bus.phase_inc)) & 'h3FFFFFF;
  endtask

  // One clock: model advances on the edge, expected bit queued, then popped
  // and compared against the DUT 1 ns after the edge.
  task automatic tick();
    bit e;
    @(posedge CLK);
    model_step();
    exp_q.push_back(m_rf[0]);
    #1;
    e = exp_q.pop_front();
    checks++;
    if (bus.RF_out !== e) begin
      errors++;
      $display("FAIL rf_stream @%0t: RF_out=%b expected %b", $time, bus.RF_out, e);
    end
    if (bus.RF_out === 1'b1) ones++;
  endtask

  task automatic test_reset();
    RSTb = 1'b1;
    bus.tx_en = 1'b0; bus.phase_inc = '0; bus.audio_in = '0;
    bus.audio_tick = 1'b0; bus.mod_shift = 2'd0;
    #2 RSTb = 1'b0;
    #1;
    checks++;
    if (bus.RF_out !== 1'b0 || dut.acc_q !== '0) begin
      errors++;
      $display("FAIL reset_init: RF_out=%b acc=%0d expected 0/0", bus.RF_out, dut.acc_q);
    end
    model_reset();
    repeat (3) tick();
    RSTb = 1'b1;
    bus.tx_en = 1'b1; bus.phase_inc = 26'h995aa;
    bus.audio_in = 8'd77; bus.audio_tick = 1'b1;
    tick();
    bus.audio_tick = 1'b0;
    repeat (40) tick();
    // Mid-cycle reset with activity: everything must clear without a clock
    #2 RSTb = 1'b0;
    #1;
    checks++;
    if (bus.RF_out !== 1'b0 || dut.u_nco.phase_q !== '0 || dut.audio_hold_q !== '0) begin
      errors++;
      $display("FAIL reset_async_a: RF_out=%b phase=%h hold=%0d expected 0", bus.RF_out,
               dut.u_nco.phase_q, dut.audio_hold_q);
    end
    checks++;
    if (dut.env_q !== '0 || dut.u_nco.tri_q !== '0 || dut.prod_q !== '0 || dut.acc_q !== '0) begin
      errors++;
      $display("FAIL reset_async_b: env=%0d tri=%0d prod=%0d acc=%0d expected 0", dut.env_q,
               dut.u_nco.tri_q, dut.prod_q, dut.acc_q);
    end
    model_reset();
    repeat (2) tick();
    RSTb = 1'b1;
    repeat (30) tick();
  endtask

  task automatic test_mute();
    bit prev, toggled;
    bus.tx_en = 1'b0; bus.phase_inc = 26'h995aa; bus.mod_shift = 2'd0;
    bus.audio_in = 8'd127; bus.audio_tick = 1'b1;
    tick();
    bus.audio_tick = 1'b0;
    ones = 0;
    repeat (1000) tick();
    checks++;
    if (ones !== 0) begin
      errors++;
      $display("FAIL mute_ones: count=%0d expected 0", ones);
    end
    bus.tx_en = 1'b1;
    prev = bus.RF_out;
    toggled = 1'b0;
    for (int i = 0; i < 4; i++) begin
      tick();
      if (bus.RF_out !== prev) toggled = 1'b1;
      prev = bus.RF_out;
    end
    checks++;
    if (!toggled) begin
      errors++;
      $display("FAIL unmute_toggle: toggled=%b expected 1", toggled);
    end
  endtask

  task automatic test_env_zero();
    bit seq [7] = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
    bus.tx_en = 1'b0; bus.mod_shift = 2'd0;
    bus.audio_in = 8'h80; bus.audio_tick = 1'b1;
    tick();
    bus.audio_tick = 1'b0;
    repeat (4) tick();
    bus.tx_en = 1'b1;
    ones = 0;
    for (int i = 0; i < 1024; i++) begin
      tick();
`ifndef AM_TX_DITHER_EN
      if (i < 7) begin
        checks++;
        if (bus.RF_out !== seq[i]) begin
          errors++;
          $display("FAIL env0_seq[%0d]: RF_out=%b expected %b", i, bus.RF_out, seq[i]);
        end
      end
`endif
    end
`ifndef AM_TX_DITHER_EN
    checks++;
    if (ones < 511 || ones > 513) begin
      errors++;
      $display("FAIL env0_density: ones=%0d expected 512+-1", ones);
    end
`endif
  endtask

  task automatic test_density();
    #2 RSTb = 1'b0;
    model_reset();
    tick();
    RSTb = 1'b1;
    bus.tx_en = 1'b1; bus.phase_inc = '0; bus.mod_shift = 2'd0;
    bus.audio_in = 8'd127; bus.audio_tick = 1'b1;
    tick();
    bus.audio_tick = 1'b0;
    repeat (4) tick();
    checks++;
    if (dut.u_nco.tri_q !== 8'sd0 || dut.prod_q !== 16'sd0) begin
      errors++;
      $display("FAIL zero_carrier: tri=%0d prod=%0d expected 0/0", dut.u_nco.tri_q, dut.prod_q);
    end
    ones = 0;
    repeat (4096) tick();
    checks++;
    if (ones < 2047 || ones > 2049) begin
      errors++;
      $display("FAIL density_dc: ones=%0d expected 2048+-1", ones);
    end
    bus.phase_inc = 26'h995aa;
    ones = 0;
    repeat (65536) tick();
    checks++;
    if (ones < 32441 || ones > 33095) begin
      errors++;
      $display("FAIL density_carrier: ones=%0d expected 32768+-327", ones);
    end
  endtask

  task automatic test_mod_shift();
    int exp_env [4] = '{228, 178, 153, 140};
    for (int s = 0; s < 4; s++) begin
      bus.mod_shift = 2'(s);
      bus.audio_in = 8'd100; bus.audio_tick = 1'b1;
      tick();
      bus.audio_tick = 1'b0;
      tick();
      checks++;
      if (int'(dut.env_q) !== exp_env[s]) begin
        errors++;
        $display("FAIL env_shift%0d: env=%0d expected %0d", s, dut.env_q, exp_env[s]);
      end
    end
    bus.mod_shift = 2'd2;
    bus.audio_in = 8'h9C;  // -100
    bus.audio_tick = 1'b1;
    tick();
    bus.audio_tick = 1'b0;
    tick();
    checks++;
    if (int'(dut.env_q) !== 103) begin
      errors++;
      $display("FAIL env_neg: env=%0d expected 103", dut.env_q);
    end
  endtask

  task automatic test_back_to_back();
    logic [7:0] last;
    bus.tx_en = 1'b1; bus.phase_inc = 26'h995aa;
    bus.audio_tick = 1'b1;
    last = 8'd0;
    for (int i = 0; i < 200; i++) begin
      last = 8'($urandom_range(0, 255));
      bus.audio_in  = last;
      bus.mod_shift = 2'($urandom_range(0, 3));
      tick();
      checks++;
      if (dut.audio_hold_q !== last) begin
        errors++;
        $display("FAIL b2b_hold[%0d]: hold=%h expected %h", i, dut.audio_hold_q, last);
      end
    end
    bus.audio_tick = 1'b0;
    bus.audio_in = ~last;
    repeat (3) tick();
    checks++;
    if (dut.audio_hold_q !== last) begin
      errors++;
      $display("FAIL hold_no_tick: hold=%h expected %h", dut.audio_hold_q, last);
    end
  endtask

  initial begin
    test_reset();
    test_mute();
    test_env_zero();
    test_density();
    test_mod_shift();
    test_back_to_back();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/am_tx_lite.md
AM_TX_LITE -- requirements
Module: am_tx_lite

Interface
REQ-001 Parameter PHASE_W, default 26, NCO phase accumulator width.
REQ-002 Parameter SAMPLE_W, default 8, audio sample width; only 8 is supported.
REQ-003 CLK  input  1  system clock; all state on its rising edge.
REQ-004 RSTb  input  1  asynchronous, active-low reset.
REQ-005 tx_en  input  1  transmit enable; low mutes RF_out.
REQ-006 phase_inc  input  PHASE_W  carrier phase increment per clock (26'h995aa = 936 kHz at 100 MHz).
REQ-007 audio_in  input  8  signed two's-complement audio sample.
REQ-008 audio_tick  input  1  single-cycle strobe; audio_in is valid in this cycle.
REQ-009 mod_shift  input  2  modulation depth; audio is arithmetically shifted right by this amount.
REQ-010 RF_out  output  1  1-bit sigma-delta AM RF stream.

Function
REQ-011 Phase accumulator (S0) SHALL add phase_inc every clock regardless of tx_en, wrapping modulo 2^PHASE_W.
REQ-012 Audio holding register (S0) SHALL load audio_in on audio_tick and hold it otherwise; a strobe on every cycle is legal.
REQ-013 Envelope (S1) SHALL be 8-bit unsigned env = 128 + (audio_hold >>> mod_shift), range 0..255, no saturation needed.
REQ-014 Carrier (S1) SHALL be a signed triangle: mag = phase[24] ? ~phase[23:17] : phase[23:17]; tri = phase[25] ? -mag : +mag, range -127..+127.
REQ-015 Product (S2) SHALL be a signed 16-bit register prod = env * tri, range ±32385.
REQ-016 Sigma-delta (S3) SHALL use an 18-bit signed accumulator: acc <= acc + x - (RF_out ? 32768 : -32768); RF_out <= (next acc >= 0); x = prod.
REQ-017 A change of the phase register SHALL first affect RF_out 3 clocks later (S0->S3).
REQ-018 While tx_en is low, acc SHALL be held at 0 and RF_out at 0; on tx_en rising, modulation resumes from acc=0 on the next clock.
REQ-019 The accumulator SHALL never overflow for any legal input (|x| < 32768).

Reset
REQ-020 On RSTb low, phase, audio_hold, env, tri, prod, acc and RF_out SHALL clear to 0 immediately, without waiting for a clock edge.
REQ-021 Reset asserted mid-operation SHALL discard pipeline contents; after release, the first RF_out update occurs on the first clock edge.

Configuration
REQ-022 Macro AM_TX_DITHER_EN: when defined, a 16-bit Fibonacci LFSR (x^16+x^14+x^13+x^11+1, seed 16'hACE1, reset to seed) SHALL advance every clock while tx_en is high, and x = prod + ({lfsr[3:0]} - 8), giving dither in the range -8..+7.
REQ-023 Without AM_TX_DITHER_EN, no LFSR SHALL exist and x = prod exactly.

Structure
REQ-024 Shared package am_pkg SHALL hold PHASE_W, SAMPLE_W, SD_FS (32768), SD_ACC_W (18), LFSR_SEED and LFSR taps.
REQ-025 Carrier generation (phase accumulator plus triangle) SHALL be a sub-module nco_tri(CLK, RSTb, phase_inc, tri).

Verification
REQ-026 Reset while tx_en=1 with activity -> all outputs 0 asynchronously; after release, RF_out follows the REQ-016 sequence from acc=0.
REQ-027 tx_en=0, audio=127, phase_inc=26'h995aa for 1000 clocks -> RF_out constantly 0; tx_en=1 -> RF_out toggles within 4 clocks.
REQ-028 audio_in=-128, mod_shift=0 (env=0), dither off -> RF_out sequence 1,1,0,1,0,1,0...; ones count over 1024 clocks = 512±1.
REQ-029 phase_inc=0, audio=127 -> tri=0, prod=0, so 50% density; phase_inc=26'h995aa -> ones density 50%±0.5% over 2^16 clocks.
REQ-030 Loopback: 1 kHz 8-bit sine audio ticked every 2048 clocks, mod_shift=1, into the existing receiver chain (nco_sq, mixer_2b, 2x cic_lite, am_demod_lite) -> demod_out shows a 1 kHz tone, peak-to-peak within 10% of a reference model.
REQ-031 mod_shift sweep 0..3 with audio=+100 -> env = 228, 178, 153, 140 respectively, 2 clocks after audio_tick.
